// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline control blocks:
// forwarding-select codes, hazard sequencer states and the operand priority rule.
package pipeline_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    // The youngest producer (EX/MEM) wins over write-back; r0 is hard-wired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_reg,
        input logic       mem_wr,
        input logic [4:0] wb_reg,
        input logic       wb_wr
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_wr && (mem_reg != REG_ZERO) && (mem_reg == src)) begin
            sel = FWD_MEM;
        end else if (wb_wr && (wb_reg != REG_ZERO) && (wb_reg == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding selects for both ALU operands.
module hazard_ctrl_fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_mem_write_reg,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_write_reg,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    assign o_fwd_a = fwd_sel(i_ex_rs, i_mem_write_reg, i_mem_reg_write,
                             i_wb_write_reg, i_wb_reg_write);
    assign o_fwd_b = fwd_sel(i_ex_rt, i_mem_write_reg, i_mem_reg_write,
                             i_wb_write_reg, i_wb_reg_write);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall / branch flush / busy-hold sequencer,
// operand forwarding and a saturating count of cycles in which the PC was held.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_write_reg,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_branch_taken,
    input  logic             ex_busy,
    input  logic [4:0]       mem_write_reg,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    // Cycles still to flush once in FLUSH; the branch cycle itself is the first.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [1:0]       r_flush_cnt;
    logic [1:0]       w_flush_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_lu;
    logic       w_pc_en;
    logic       w_ifid_en;
    logic       w_ifid_flush;
    logic       w_idex_en;
    logic       w_idex_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    hazard_ctrl_fwd_unit u_fwd (
        .i_ex_rs         (ex_rs),
        .i_ex_rt         (ex_rt),
        .i_mem_write_reg (mem_write_reg),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_write_reg  (wb_write_reg),
        .i_wb_reg_write  (wb_reg_write),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    assign w_lu = ex_reg_write && ex_mem_to_reg && (ex_write_reg != REG_ZERO) &&
                  ((id_uses_rs && (id_rs == ex_write_reg)) ||
                   (id_uses_rt && (id_rt == ex_write_reg)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_flush_nxt  = r_flush_cnt;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_idex_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        case (r_state)
            RUN: begin
                // Branch beats busy, busy beats load-use.
                if (ex_branch_taken) begin
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        w_state_nxt = FLUSH;
                        w_flush_nxt = FLUSH_INIT;
                    end
                end else if (ex_busy) begin
                    w_pc_en   = 1'b0;
                    w_ifid_en = 1'b0;
                    w_idex_en = 1'b0;
                end else if (w_lu) begin
                    w_pc_en      = 1'b0;
                    w_ifid_en    = 1'b0;
                    w_idex_flush = 1'b1;
                    w_state_nxt  = LU_STALL;
                end
            end
            LU_STALL: begin
                w_state_nxt = RUN;
            end
            FLUSH: begin
                w_ifid_flush = 1'b1;
                w_flush_nxt  = r_flush_cnt - 2'd1;
                if (r_flush_cnt <= 2'd1) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_flush_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Reset holds the whole front end frozen and bubbled, independent of the clock.
    assign pc_en      = rst ? 1'b0    : w_pc_en;
    assign ifid_en    = rst ? 1'b0    : w_ifid_en;
    assign idex_en    = rst ? 1'b0    : w_idex_en;
    assign ifid_flush = rst ? 1'b1    : w_ifid_flush;
    assign idex_flush = rst ? 1'b1    : w_idex_flush;
    assign fwd_a      = rst ? FWD_REG : w_fwd_a;
    assign fwd_b      = rst ? FWD_REG : w_fwd_b;
    assign stall_cnt  = r_stall_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// each cycle's expected outputs queued by the driver and compared by a negedge monitor.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int CNT_W     = 4;
  localparam int FLUSH_CYC = 2;
  localparam int W         = CNT_W + 11;
  localparam int SAT       = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
  logic             id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_to_reg;
  logic             ex_branch_taken, ex_busy, mem_reg_write, wb_reg_write;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic [1:0]       fwd_a, fwd_b, dbg_state;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_write_reg    (ex_write_reg),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_branch_taken (ex_branch_taken),
    .ex_busy         (ex_busy),
    .mem_write_reg   (mem_write_reg),
    .mem_reg_write   (mem_reg_write),
    .wb_write_reg    (wb_write_reg),
    .wb_reg_write    (wb_reg_write),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cnt       (stall_cnt),
    .dbg_state       (dbg_state)
  );

  // ---------------- reference model ----------------
  // Expected vector: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, fwd_a, fwd_b, state, stall_cnt}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  int m_flush_left = 0;  // further flush cycles owed after a taken branch
  bit m_after_lu = 0;    // the previous cycle was a load-use bubble
  int m_stall = 0;

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_reg_write && mem_write_reg != 5'd0 && mem_write_reg == src) return 2'b01;
    if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == src) return 2'b10;
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_write_reg = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_branch_taken = 0; ex_busy = 0;
    mem_write_reg = 0; mem_reg_write = 0; wb_write_reg = 0; wb_reg_write = 0;
  endtask

  // Called at posedge+1 with inputs already set; queues this cycle's expectation,
  // then advances the model across the next clock edge.
  task automatic step();
    logic pc, ie, ifl, xe, xfl;
    logic [1:0] fa, fb, st;
    bit lu;
    lu = ex_reg_write && ex_mem_to_reg && ex_write_reg != 5'd0 &&
         ((id_uses_rs && id_rs == ex_write_reg) || (id_uses_rt && id_rt == ex_write_reg));
    if (rst) begin
      m_flush_left = 0; m_after_lu = 0; m_stall = 0;
      pc = 0; ie = 0; ifl = 1; xe = 0; xfl = 1; fa = 2'b00; fb = 2'b00; st = RUN;
    end else begin
      fa = m_fwd(ex_rs);
      fb = m_fwd(ex_rt);
      pc = 1; ie = 1; xe = 1; ifl = 0; xfl = 0;
      if (m_flush_left > 0) begin
        st = FLUSH; ifl = 1;
      end else if (m_after_lu) begin
        st = LU_STALL;
      end else begin
        st = RUN;
        if (ex_branch_taken) begin
          ifl = 1; xfl = 1;
        end else if (ex_busy) begin
          pc = 0; ie = 0; xe = 0;
        end else if (lu) begin
          pc = 0; ie = 0; xfl = 1;
        end
      end
    end
    exp_q.push_back({pc, ie, ifl, xe, xfl, fa, fb, st, CNT_W'(m_stall)});
    @(posedge clk);
    if (!rst) begin
      if (!pc && m_stall < SAT) m_stall++;
      if (m_flush_left > 0) m_flush_left--;
      else if (m_after_lu) m_after_lu = 0;
      else if (ex_branch_taken) m_flush_left = FLUSH_CYC - 1;
      else if (!ex_busy && lu) m_after_lu = 1;
    end
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, fwd_a, fwd_b, dbg_state, stall_cnt};
      check("ctl_en_flush", 16'(a[W-1:W-5]), 16'(e[W-1:W-5]));
      check("fwd_ab", 16'(a[CNT_W+5:CNT_W+2]), 16'(e[CNT_W+5:CNT_W+2]));
      check("state", 16'(a[CNT_W+1:CNT_W]), 16'(e[CNT_W+1:CNT_W]));
      check("stall_cnt", 16'(a[CNT_W-1:0]), 16'(e[CNT_W-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    step(); step();
    rst = 0;
    step();

    // forwarding priority, then r0 never forwarded
    ex_rs = 8; ex_rt = 8; mem_write_reg = 8; mem_reg_write = 1; wb_write_reg = 8; wb_reg_write = 1;
    step();
    mem_reg_write = 0;
    step();
    ex_rs = 0; ex_rt = 0; mem_write_reg = 0; wb_write_reg = 0; mem_reg_write = 1;
    step();
    clear_inputs();

    // load-use on rt
    ex_write_reg = 9; ex_reg_write = 1; ex_mem_to_reg = 1; id_rt = 9; id_uses_rt = 1;
    step();
    clear_inputs();
    mem_write_reg = 9; mem_reg_write = 1; ex_rt = 9;
    step(); step();
    clear_inputs();

    // branch together with load-use and busy; repeat branch/busy inside FLUSH
    ex_write_reg = 9; ex_reg_write = 1; ex_mem_to_reg = 1; id_rs = 9; id_uses_rs = 1;
    ex_branch_taken = 1; ex_busy = 1;
    step();
    step();
    clear_inputs();
    step(); step();

    // multi-cycle hold, then saturation
    ex_busy = 1;
    repeat (5) step();
    ex_busy = 0;
    step();
    ex_busy = 1;
    repeat (20) step();
    ex_busy = 0;
    step();

    // asynchronous reset asserted while in FLUSH
    ex_branch_taken = 1;
    step();
    ex_branch_taken = 0;
    rst = 1;
    step(); step();
    rst = 0;
    step(); step();

    // random traffic over a small register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_write_reg = 5'($urandom_range(0, 3));
      ex_reg_write = 1'($urandom_range(0, 1));
      ex_mem_to_reg = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      if (ex_busy) ex_busy = ($urandom_range(0, 2) != 0);
      else ex_busy = ($urandom_range(0, 9) == 0);
      mem_write_reg = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_write_reg = 5'($urandom_range(0, 3));
      wb_reg_write = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0;
    clear_inputs();
    step();

    @(negedge clk); #1;
    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
